// File: rtl/reg_n_unload_if.sv
// Handshake/serial bundle for the serial unloader of the N-bit delay register bank.
// slave  : the unloader (takes words, drives the serial stream).
// master : the word producer / serial consumer side.
interface reg_n_unload_if #(
  parameter int N = 4
);
  localparam int W = 1 << N;

  logic [W-1:0] d;
  logic         d_valid;
  logic         d_ready;
  logic         sout;
  logic         sout_valid;
  logic         sof;
  logic         eow;
  logic         busy;

  modport master (
    output d, d_valid,
    input  d_ready, sout, sout_valid, sof, eow, busy
  );

  modport slave (
    input  d, d_valid,
    output d_ready, sout, sout_valid, sof, eow, busy
  );
endinterface

// File: rtl/reg_n_unload.sv
// Serial unloader: takes one 2**N-bit word per handshake and shifts it out
// MSB first, one bit per clock, then idles GAP cycles before taking the next.
// Every output is decoded from registered state/counters; d and d_valid only
// feed next-state logic, so there is no input-to-output combinational path.
module reg_n_unload #(
  parameter int N   = 4,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           rst,
  reg_n_unload_if.slave  bus
);
  localparam int W = 1 << N;
  // Terminal counts; GAP_LAST is unused when GAP==0 (SHIFT goes straight to IDLE).
  localparam logic [N-1:0] BIT_LAST = N'(W - 1);
  localparam logic [N-1:0] GAP_LAST = N'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [N-1:0]   bcnt_q, bcnt_d;
  logic [N-1:0]   gcnt_q, gcnt_d;

  // State and datapath registers; async reset drops any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    bcnt_d         = bcnt_q;
    gcnt_d         = gcnt_q;
    bus.d_ready    = 1'b0;
    bus.busy       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.sout       = 1'b0;
    bus.sof        = 1'b0;
    bus.eow        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // rst gating keeps d_ready low for the whole reset pulse.
        bus.d_ready = ~rst;
        if (bus.d_valid) begin
          shreg_d = bus.d;
          bcnt_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bus.busy       = 1'b1;
        bus.sout_valid = 1'b1;
        bus.sout       = shreg_q[W-1];
        bus.sof        = (bcnt_q == '0);
        bus.eow        = (bcnt_q == BIT_LAST);
        shreg_d        = {shreg_q[W-2:0], 1'b0};
        if (bcnt_q == BIT_LAST) begin
          // Counter never wraps inside a word: terminal count always leaves SHIFT.
          bcnt_d  = '0;
          gcnt_d  = '0;
          state_d = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end

      S_GAP: begin
        bus.busy = 1'b1;
        if (gcnt_q == GAP_LAST) begin
          gcnt_d  = '0;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        bcnt_d  = '0;
        gcnt_d  = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_reg_n_unload.sv
// Bench for reg_n_unload: two instances (GAP=2 and GAP=0) share stimulus.
// A schedule model books, per accepted word, the output slots it occupies;
// each cycle both DUTs are compared against their bookings.
module tb_reg_n_unload;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int SLOTS = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_n_unload_if #(.N(N)) bus0 ();
  reg_n_unload_if #(.N(N)) bus1 ();

  reg_n_unload #(.N(N), .GAP(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  reg_n_unload #(.N(N), .GAP(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Per-model slot bookings: slot s = cycle after edge s since reset release.
  bit ev   [2][SLOTS];
  bit ebit [2][SLOTS];
  bit esof [2][SLOTS];
  bit eeow [2][SLOTS];
  bit ebsy [2][SLOTS];
  int gapv [2] = '{2, 0};
  int slot;

  logic [15:0] rx0;
  int nv0, run0, run1, gap_meas0, gap_meas1;
  int prev_sof0, prev_sof1, per0, per1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] obs(input int m);
    if (m == 0)
      return {bus0.d_ready, bus0.busy, bus0.sout_valid, bus0.sout, bus0.sof, bus0.eow};
    return {bus1.d_ready, bus1.busy, bus1.sout_valid, bus1.sout, bus1.sof, bus1.eow};
  endfunction

  function automatic logic [5:0] expv(input int m, input int s);
    logic b, v;
    b = ebsy[m][s];
    v = ev[m][s];
    return {~b, b, v, v & ebit[m][s], esof[m][s], eeow[m][s]};
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 2; m++)
      for (int s = 0; s < SLOTS; s++) begin
        ev[m][s] = 0; ebit[m][s] = 0; esof[m][s] = 0; eeow[m][s] = 0; ebsy[m][s] = 0;
      end
    slot = 0;
  endtask

  // Word accepted at edge k: bits occupy slots k..k+W-1, gap follows.
  task automatic sched(input int m, input int k, input logic [15:0] w);
    for (int i = 0; i < W; i++) begin
      ev[m][k+i]   = 1;
      ebit[m][k+i] = w[W-1-i];
      esof[m][k+i] = (i == 0);
      eeow[m][k+i] = (i == W-1);
      ebsy[m][k+i] = 1;
    end
    for (int j = 0; j < gapv[m]; j++) ebsy[m][k+W+j] = 1;
  endtask

  task automatic cycle(input logic v, input logic [15:0] w);
    bus0.d_valid = v; bus0.d = w;
    bus1.d_valid = v; bus1.d = w;
    @(posedge clk);
    for (int m = 0; m < 2; m++)
      if (v && !ebsy[m][slot]) sched(m, slot + 1, w);
    slot++;
    @(negedge clk);
    chk($sformatf("dut0_slot%0d", slot), obs(0), expv(0, slot));
    chk($sformatf("dut1_slot%0d", slot), obs(1), expv(1, slot));
    if (bus0.sout_valid) begin
      rx0 = {rx0[14:0], bus0.sout};
      nv0++;
    end
    if (bus0.sof) begin gap_meas0 = run0; per0 = slot - prev_sof0; prev_sof0 = slot; end
    if (bus1.sof) begin gap_meas1 = run1; per1 = slot - prev_sof1; prev_sof1 = slot; end
    run0 = bus0.sout_valid ? 0 : run0 + 1;
    run1 = bus1.sout_valid ? 0 : run1 + 1;
  endtask

  // Asynchronous reset mid-cycle; outputs must drop before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async0", obs(0), 6'd0);
    chk("rst_async1", obs(1), 6'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold0", obs(0), 6'd0);
    chk("rst_hold1", obs(1), 6'd0);
    rst = 1'b0;
    bus0.d_valid = 1'b0; bus1.d_valid = 1'b0;
    clear_model();
    run0 = 0; run1 = 0;
  endtask

  initial begin
    bus0.d_valid = 1'b0; bus0.d = '0;
    bus1.d_valid = 1'b0; bus1.d = '0;
    rx0 = '0; nv0 = 0; run0 = 0; run1 = 0;
    gap_meas0 = -1; gap_meas1 = -1;
    prev_sof0 = 0; prev_sof1 = 0; per0 = 0; per1 = 0;
    clear_model();

    // Power-on reset
    @(negedge clk);
    @(negedge clk);
    chk("por0", obs(0), 6'd0);
    chk("por1", obs(1), 6'd0);
    rst = 1'b0;

    // Idle after release
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0);

    // Single word A5C3
    rx0 = '0; nv0 = 0;
    cycle(1'b1, 16'hA5C3);
    for (int i = 0; i < 22; i++) cycle(1'b0, 16'($urandom));
    chk("a5c3_stream", rx0, 16'hA5C3);
    chk("a5c3_nbits", nv0, 16);

    // Back-to-back: FFFF then 0001 with d_valid held
    cycle(1'b1, 16'hFFFF);
    for (int i = 0; i < 30; i++) cycle(1'b1, 16'h0001);
    for (int i = 0; i < 25; i++) cycle(1'b0, 16'h0);
    chk("b2b_last_word", rx0, 16'h0001);
    chk("b2b_gap_g2", gap_meas0, 3);
    chk("b2b_gap_g0", gap_meas1, 1);
    chk("b2b_period_g2", per0, 19);
    chk("b2b_period_g0", per1, 17);

    // d changes during SHIFT
    cycle(1'b1, 16'h8000);
    for (int i = 0; i < 25; i++) cycle(1'b0, 16'h1234);
    chk("d_change_word", rx0, 16'h8000);

    // Reset after 7 bits of FFFF
    nv0 = 0;
    cycle(1'b1, 16'hFFFF);
    for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0);
    chk("pre_rst_bits", nv0, 7);
    do_reset();
    nv0 = 0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'hFFFF);
    chk("no_residual", nv0, 0);

    // Randomized traffic with periodic resets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 600; i++)
        cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 16'($urandom));
      do_reset();
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the stimulus process ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
